// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared definitions for the serial adder slice.
//   state_e   : controller states (IDLE accepts, RUN computes, DONE presents)
//   DEF_WIDTH : default operand/result width
//   DEF_DIGIT : default number of bits processed per cycle
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_DIGIT = 1;

endpackage

// File: rtl/serial_adder_fa_cell.sv
// fa_cell: one-bit full adder made of two half adders and an OR for carry.
//   a, b : operand bits
//   ci   : carry in
//   s    : sum bit
//   co   : carry out
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p_s;
  logic g1_s;
  logic g2_s;

  // first half adder combines the operands, second folds in the carry
  assign p_s  = a ^ b;
  assign g1_s = a & b;
  assign s    = p_s ^ ci;
  assign g2_s = p_s & ci;
  assign co   = g1_s | g2_s;

endmodule

// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor, DIGIT bits per clock.
//   clk, rst_n              : clock, asynchronous active-low reset
//   start_valid/start_ready : operation handshake (a, b, cin, sub captured)
//   res_valid/res_ready     : result handshake (sum, cout, ovf held stable)
//   sum  : result modulo 2^WIDTH
//   cout : carry out of the MSB (subtract: 1 means no borrow)
//   ovf  : two's-complement signed overflow
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((DIGIT < 1) || (WIDTH < 2) || ((WIDTH % DIGIT) != 0)) begin : g_param_check
    $error("serial_adder: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_e           state_r;
  state_e           state_s;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH-1:0] sum_r;
  logic             carry_r;
  logic             cout_r;
  logic             ovf_r;
  logic             start_ready_r;
  logic             res_valid_r;
  logic [CW-1:0]    cnt_r;

  logic [DIGIT:0]   c_s;
  logic [DIGIT-1:0] slice_s;
  logic [WIDTH-1:0] slice_ext_s;
  logic [WIDTH-1:0] acc_next_s;
  logic             last_s;

  assign last_s = (cnt_r == CW'(N - 1));

  // ripple chain for the current slice; c_s[0] is the carry kept between slices
  assign c_s[0] = carry_r;
  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    fa_cell u_fa (
      .a  (a_r[i]),
      .b  (b_r[i]),
      .ci (c_s[i]),
      .s  (slice_s[i]),
      .co (c_s[i+1])
    );
  end

  // new slice enters the accumulator at the top; after N slices the LSB slice sits at bit 0
  always_comb begin
    slice_ext_s              = {WIDTH{1'b0}};
    slice_ext_s[DIGIT-1:0]   = slice_s;
    acc_next_s               = (acc_r >> DIGIT) | (slice_ext_s << (WIDTH - DIGIT));
  end

  // next-state logic of the controller
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_valid) state_s = RUN;
        else             state_s = IDLE;
      end
      RUN: begin
        if (last_s) state_s = DONE;
        else        state_s = RUN;
      end
      DONE: begin
        if (res_ready) state_s = IDLE;
        else           state_s = DONE;
      end
      default: state_s = IDLE;
    endcase
  end

  // state register plus handshake flags registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= IDLE;
      start_ready_r <= 1'b1;
      res_valid_r   <= 1'b0;
    end else begin
      state_r       <= state_s;
      start_ready_r <= (state_s == IDLE);
      res_valid_r   <= (state_s == DONE);
    end
  end

  // operand capture, slice processing and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      acc_r   <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      cnt_r   <= CW'(0);
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            // subtract as a + ~b + ~cin so the same adder serves both modes
            a_r     <= a;
            b_r     <= sub ? ~b : b;
            carry_r <= sub ? ~cin : cin;
            cnt_r   <= CW'(0);
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= c_s[DIGIT];
          acc_r   <= acc_next_s;
          cnt_r   <= last_s ? CW'(0) : cnt_r + CW'(1);
          if (last_s) begin
            sum_r  <= acc_next_s;
            cout_r <= c_s[DIGIT];
            ovf_r  <= c_s[DIGIT-1] ^ c_s[DIGIT];
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign start_ready = start_ready_r;
  assign res_valid   = res_valid_r;
  assign sum         = sum_r;
  assign cout        = cout_r;
  assign ovf         = ovf_r;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed vector table on an 8-bit/1-bit-digit instance,
// hand-written stall and mid-run reset sequences, and a model-checked run on
// a 16-bit/4-bit-digit instance.
module tb_serial_adder;

  logic       clk;
  logic       rst_n;

  logic       sv8, sr8, rv8, rr8, cin8, sub8, cout8, ovf8;
  logic [7:0] a8, b8, sum8;

  logic        sv16, sr16, rv16, rr16, cin16, sub16, cout16, ovf16;
  logic [15:0] a16, b16, sum16;

  int checks;
  int errors;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .cin(cin8), .sub(sub8),
    .res_valid(rv8), .res_ready(rr8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clk(clk), .rst_n(rst_n),
    .start_valid(sv16), .start_ready(sr16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16),
    .res_valid(rv16), .res_ready(rr16),
    .sum(sum16), .cout(cout16), .ovf(ovf16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // full operation on the 8-bit instance; inputs are scrambled after accept
  task automatic op8(input logic [7:0] ia, input logic [7:0] ib, input logic ic, input logic is,
                     output logic [7:0] rs, output logic rc, output logic ro, output int lat);
    int k;
    @(negedge clk);
    a8 = ia; b8 = ib; cin8 = ic; sub8 = is; sv8 = 1'b1;
    k = 0;
    while (!sr8 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    sv8 = 1'b0; a8 = ~ia; b8 = ~ib; cin8 = ~ic; sub8 = ~is;
    lat = 0;
    while (!rv8 && lat < 50) begin @(posedge clk); #1; lat++; end
    rs = sum8; rc = cout8; ro = ovf8;
    rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
  endtask

  task automatic op16(input logic [15:0] ia, input logic [15:0] ib, input logic ic, input logic is,
                      output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    int k;
    @(negedge clk);
    a16 = ia; b16 = ib; cin16 = ic; sub16 = is; sv16 = 1'b1;
    k = 0;
    while (!sr16 && k < 50) begin @(negedge clk); k++; end
    @(posedge clk); #1;
    sv16 = 1'b0; a16 = ~ia; b16 = ~ib;
    lat = 0;
    while (!rv16 && lat < 50) begin @(posedge clk); #1; lat++; end
    rs = sum16; rc = cout16; ro = ovf16;
    rr16 = 1'b1;
    @(posedge clk); #1;
    rr16 = 1'b0;
  endtask

  // arithmetic reference: signed overflow from operand/result signs
  function automatic logic [17:0] model16(input logic [15:0] ia, input logic [15:0] ib,
                                          input logic ic, input logic is);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] full;
    logic        o;
    bb   = is ? ~ib : ib;
    c0   = is ? ~ic : ic;
    full = {1'b0, ia} + {1'b0, bb} + {16'd0, c0};
    o    = (ia[15] == bb[15]) && (full[15] != ia[15]);
    return {o, full[16], full[15:0]};
  endfunction

  initial begin
    logic [7:0]  rs;
    logic [15:0] rs16;
    logic        rc, ro, seen;
    logic [17:0] exp16;
    logic [15:0] ra, rb;
    logic        rcin, rsub;
    int          lat;

    checks = 0;
    errors = 0;

    //              a       b      cin   sub   sum    cout  ovf
    vecs[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[2]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vecs[3]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vecs[4]  = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0};
    vecs[5]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[7]  = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[8]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[9]  = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1};
    vecs[10] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[11] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0E, 1'b1, 1'b0};

    rst_n = 1'b0;
    sv8 = 1'b0; rr8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0;
    sv16 = 1'b0; rr16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000; cin16 = 1'b0; sub16 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("reset_start_ready8", {31'd0, sr8}, 32'd1);
    check("reset_res_valid8", {31'd0, rv8}, 32'd0);
    check("reset_sum8", {24'd0, sum8}, 32'd0);
    check("reset_cout8", {31'd0, cout8}, 32'd0);
    check("reset_ovf8", {31'd0, ovf8}, 32'd0);
    check("reset_start_ready16", {31'd0, sr16}, 32'd1);
    check("reset_res_valid16", {31'd0, rv16}, 32'd0);

    // vector table
    for (int i = 0; i < 12; i++) begin
      op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, rs, rc, ro, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd8);
      check($sformatf("vec%0d_sum", i), {24'd0, rs}, {24'd0, vecs[i].sum});
      check($sformatf("vec%0d_cout", i), {31'd0, rc}, {31'd0, vecs[i].cout});
      check($sformatf("vec%0d_ovf", i), {31'd0, ro}, {31'd0, vecs[i].ovf});
    end

    // stall in DONE with res_ready low; start_valid and operand changes ignored
    @(negedge clk);
    a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b0; sub8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    lat = 0;
    while (!rv8 && lat < 50) begin @(posedge clk); #1; lat++; end
    check("stall_latency", lat, 32'd8);
    for (int i = 0; i < 5; i++) begin
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; sv8 = 1'b1;
      @(posedge clk); #1;
      check($sformatf("stall%0d_res_valid", i), {31'd0, rv8}, 32'd1);
      check($sformatf("stall%0d_sum", i), {24'd0, sum8}, 32'h4B);
      check($sformatf("stall%0d_start_ready", i), {31'd0, sr8}, 32'd0);
    end
    sv8 = 1'b0;
    rr8 = 1'b1;
    @(posedge clk); #1;
    rr8 = 1'b0;
    check("handshake_res_valid", {31'd0, rv8}, 32'd0);
    check("handshake_start_ready", {31'd0, sr8}, 32'd1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_hold_sum", {24'd0, sum8}, 32'h4B);
    check("idle_no_stray_accept", {31'd0, sr8}, 32'd1);

    // reset pulse while slice 3 is being processed
    @(negedge clk);
    a8 = 8'h21; b8 = 8'h10; cin8 = 1'b0; sub8 = 1'b0; sv8 = 1'b1;
    @(posedge clk); #1;
    sv8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_res_valid", {31'd0, rv8}, 32'd0);
    check("midrun_reset_sum", {24'd0, sum8}, 32'd0);
    check("midrun_reset_cout", {31'd0, cout8}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("after_release_start_ready", {31'd0, sr8}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (rv8) seen = 1'b1;
    end
    check("aborted_no_result", {31'd0, seen}, 32'd0);
    op8(8'h55, 8'h2A, 1'b1, 1'b0, rs, rc, ro, lat);
    check("post_reset_latency", lat, 32'd8);
    check("post_reset_sum", {24'd0, rs}, 32'h80);
    check("post_reset_ovf", {31'd0, ro}, 32'd1);

    // 16-bit, 4-bit digits: corner operands then random against the model
    for (int i = 0; i < 260; i++) begin
      if (i == 0) begin
        ra = 16'h7FFF; rb = 16'h0001; rcin = 1'b0; rsub = 1'b0;
      end else if (i == 1) begin
        ra = 16'h8000; rb = 16'h0001; rcin = 1'b0; rsub = 1'b1;
      end else if (i == 2) begin
        ra = 16'hFFFF; rb = 16'hFFFF; rcin = 1'b1; rsub = 1'b0;
      end else begin
        ra = 16'($urandom); rb = 16'($urandom);
        rcin = 1'($urandom); rsub = 1'($urandom);
      end
      exp16 = model16(ra, rb, rcin, rsub);
      op16(ra, rb, rcin, rsub, rs16, rc, ro, lat);
      check($sformatf("r%0d_latency", i), lat, 32'd4);
      check($sformatf("r%0d_result a=%h b=%h cin=%b sub=%b", i, ra, rb, rcin, rsub),
            {14'd0, ro, rc, rs16}, {14'd0, exp16});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
